// File: rtl/adder_fc_pkg.sv
// Shared types and constants for the adder operand collector slice.
package adder_fc_pkg;

  localparam int operand_width = 8;
  localparam int fifo_depth    = 2;

  typedef enum logic [0:0] {
    A_WAIT = 1'b0,
    B_WAIT = 1'b1
  } collector_state_t;

endpackage

// File: rtl/adder_operand_collector_if.sv
// Byte-in / pair-out valid/ready bundle between the operand source, the
// collector and the adder. The master drives bytes and accepts pairs;
// the slave (the collector) does the opposite.
interface adder_operand_collector_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_a, out_b
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_a, out_b
  );

endinterface

// File: rtl/ff_fifo_depth_2.sv
// Registered 2-entry FIFO. The head entry is read straight from storage,
// so pop_data only changes on a clock edge. Pushes when full and pops when
// empty are ignored.
module ff_fifo_depth_2
  import adder_fc_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  logic [width-1:0] mem_q [fifo_depth];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == 2'd0);
  assign full     = (count_q == 2'(fifo_depth));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Storage, 1-bit wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared on reset so the head reads as zero while
      // empty; without that requirement a data memory would not need reset.
      for (int i = 0; i < fifo_depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, whatever the statement order.
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adder_operand_collector.sv
// Pairs consecutive operand bytes into (a, b) and queues them in a 2-entry
// registered FIFO feeding the adder. in_ready depends only on registered
// state, so no ready path crosses this stage.
// Optional feature macro: ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN adds the
// pair_cnt output counting delivered pairs.
module adder_operand_collector
  import adder_fc_pkg::*;
#(
  parameter int W = operand_width
) (
  input  logic                       clk,
  input  logic                       rst,
  adder_operand_collector_if.slave   bus,
  output logic                       half_pair
`ifdef ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN
  ,
  output logic [15:0]                pair_cnt
`endif
);

  collector_state_t state_q, state_d;
  logic [W-1:0]     a_q;
  logic             in_ready;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [2*W-1:0]   head;

  // Collector state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= A_WAIT;
    else     state_q <= state_d;
  end

  // Next state, input ready and FIFO push. A pop in the same cycle never
  // frees a slot, which keeps out_ready out of the in_ready cone.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    in_ready = 1'b1;
    push     = 1'b0;
    case (state_q)
      A_WAIT: begin
        if (bus.in_valid) state_d = B_WAIT;
      end
      B_WAIT: begin
        in_ready = !fifo_full;
        if (bus.in_valid && !fifo_full) begin
          push    = 1'b1;
          state_d = A_WAIT;
        end
      end
      default: state_d = A_WAIT;
    endcase
  end

  // Hold the first operand while waiting for its partner.
  always_ff @(posedge clk) begin
    if (rst)                                       a_q <= '0;
    else if (state_q == A_WAIT && bus.in_valid)    a_q <= bus.in_data;
  end

  ff_fifo_depth_2 #(
    .width (2 * W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({a_q, bus.in_data}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_a     = head[2*W-1:W];
  assign bus.out_b     = head[W-1:0];
  assign half_pair     = (state_q == B_WAIT);

`ifdef ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN
  logic [15:0] pair_cnt_q;

  // Count delivered pairs, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)      pair_cnt_q <= '0;
    else if (pop) pair_cnt_q <= pair_cnt_q + 16'd1;
  end

  assign pair_cnt = pair_cnt_q;
`endif

endmodule

// File: tb/tb_adder_operand_collector.sv
// Directed self-checking bench for adder_operand_collector. Inputs change
// and outputs are sampled 1 time unit after each rising edge.
module tb_adder_operand_collector;
  import adder_fc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic half_pair;
`ifdef ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN
  logic [15:0] pair_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  adder_operand_collector_if #(.W(operand_width)) bus ();

  adder_operand_collector #(
    .W (operand_width)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .half_pair (half_pair)
`ifdef ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN
    ,
    .pair_cnt  (pair_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait, bounded, until it is accepted.
  task automatic send_byte(input logic [7:0] d);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h never accepted", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // 1. Reset held two cycles, then idle.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready",  32'(bus.in_ready),  1);
    check("rst_half_pair", 32'(half_pair),     0);
    check("rst_out_a",     32'(bus.out_a),     0);
    check("rst_out_b",     32'(bus.out_b),     0);

    // 2. Back-to-back pair with the adder ready.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h12;
    step();
    check("t2_half_after_a", 32'(half_pair),     1);
    check("t2_no_valid_yet", 32'(bus.out_valid), 0);
    bus.in_data = 8'h34;
    step();
    bus.in_valid = 1'b0;
    check("t2_valid",     32'(bus.out_valid), 1);
    check("t2_out_a",     32'(bus.out_a),     32'h12);
    check("t2_out_b",     32'(bus.out_b),     32'h34);
    check("t2_half_done", 32'(half_pair),     0);
    step();
    check("t2_single_cycle", 32'(bus.out_valid), 0);

    // 3. Fill the FIFO under backpressure, then drain.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h06;
    check("t3_full_in_ready", 32'(bus.in_ready),  0);
    check("t3_full_half",     32'(half_pair),     1);
    check("t3_head_a",        32'(bus.out_a),     32'h01);
    check("t3_head_b",        32'(bus.out_b),     32'h02);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stall_in_ready", 32'(bus.in_ready), 0);
      check("t3_stall_head_a",   32'(bus.out_a),    32'h01);
    end
    bus.out_ready = 1'b1;
    step();
    check("t3_pop1_valid", 32'(bus.out_valid), 1);
    check("t3_pop1_a",     32'(bus.out_a),     32'h03);
    check("t3_pop1_b",     32'(bus.out_b),     32'h04);
    check("t3_pop1_ready", 32'(bus.in_ready),  1);
    step();
    bus.in_valid = 1'b0;
    check("t3_pushpop_valid", 32'(bus.out_valid), 1);
    check("t3_pushpop_a",     32'(bus.out_a),     32'h05);
    check("t3_pushpop_b",     32'(bus.out_b),     32'h06);
    check("t3_pushpop_half",  32'(half_pair),     0);
    step();
    check("t3_drained", 32'(bus.out_valid), 0);

    // 4. Head held stable under backpressure, then exactly one pop.
    bus.out_ready = 1'b0;
    send_byte(8'hA1);
    send_byte(8'hB2);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(bus.out_valid), 1);
      check("t4_hold_a",     32'(bus.out_a),     32'hA1);
      check("t4_hold_b",     32'(bus.out_b),     32'hB2);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t4_one_pop", 32'(bus.out_valid), 0);

    // 5. Reset discards a held a byte; with queued pairs too.
    send_byte(8'hAA);
    check("t5_half_aa", 32'(half_pair), 1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_rst_half",  32'(half_pair),     0);
    check("t5_rst_valid", 32'(bus.out_valid), 0);
    check("t5_rst_ready", 32'(bus.in_ready),  1);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("t5_valid", 32'(bus.out_valid), 1);
    check("t5_out_a", 32'(bus.out_a),     32'hBB);
    check("t5_out_b", 32'(bus.out_b),     32'hCC);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_flush_valid", 32'(bus.out_valid), 0);
    check("t5_flush_a",     32'(bus.out_a),     0);
    check("t5_flush_b",     32'(bus.out_b),     0);

`ifdef ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN
    // 6. Pair counter: three deliveries, then wrap from 0xFFFF.
    check("t6_cnt_rst", 32'(pair_cnt), 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i));
    step();
    check("t6_cnt_3", 32'(pair_cnt), 3);
    bus.out_ready = 1'b0;
    send_byte(8'h77);
    send_byte(8'h88);
    force dut.pair_cnt_q = 16'hFFFF;
    #1;
    release dut.pair_cnt_q;
    check("t6_cnt_forced", 32'(pair_cnt), 32'hFFFF);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t6_cnt_wrap", 32'(pair_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_operand_collector.md
Name: adder_operand_collector

Overview:
Upstream stage of the adder with flow control. It accepts a single narrow valid/ready stream of operand bytes and pairs consecutive bytes as (a, b). Completed pairs go into a 2-entry registered FIFO, which drives the adder's operand valid/ready interface. in_ready does not depend combinationally on out_ready, so no ready path crosses the stage.

Parameters:
W, 8, operand width in bits (in_data, out_a, out_b)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream byte valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  W  operand byte; even-numbered token is a, odd-numbered token is b
out_valid  output  1  a pair is presented on out_a/out_b
out_ready  input  1  downstream (adder) accepts the pair
out_a  output  W  first operand of head pair
out_b  output  W  second operand of head pair
half_pair  output  1  a is held and the block is waiting for b

Behaviour:
- Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready. Both are sampled at the rising edge of clk.
- Collector FSM has two states:
  - A_WAIT (reset state): on input transfer, latch in_data into a_q and go to B_WAIT.
  - B_WAIT: on input transfer, push {a_q, in_data} into the FIFO and go to A_WAIT.
- in_ready:
  - A_WAIT: 1.
  - B_WAIT: !fifo_full, where fifo_full is registered (count == 2).
  - A pop in the same cycle does NOT free a slot for a push when the FIFO is full. This is a deliberate choice to avoid a combinational out_ready-to-in_ready path.
- FIFO: 2 entries of 2W bits, with a registered count of 0..2.
  - out_valid = (count != 0). out_a/out_b come from the head entry.
  - out_a/out_b are held stable while out_valid && !out_ready.
  - Simultaneous push and pop with count 1: count stays 1, pointers both advance, head becomes the new pair.
  - Simultaneous push and pop with count 2: cannot occur, because in_ready is 0.
  - Pop with count 0: cannot occur.
- Pointers are 1 bit each and wrap naturally at 2.
- Latency: the b byte accepted at edge N makes the pair visible on out_valid/out_a/out_b after edge N, i.e. one cycle later. No combinational in-to-out path.
- Throughput: at most one pair per 2 cycles, limited by the 1-byte input. Sustained when out_ready = 1.
- half_pair = (state == B_WAIT).
- Reset values: state = A_WAIT, count = 0, pointers = 0, out_valid = 0, half_pair = 0, in_ready = 1. out_a and out_b are 0 (FIFO storage is cleared).
- Reset mid-operation: a held a_q and all queued pairs are discarded. The next byte after reset is treated as a. rst has priority over any transfer in the same cycle.
- No data-dependent behaviour: bytes are passed through unmodified, with no arithmetic.

Optional Feature:
ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN
- Defined: adds output pair_cnt [15:0].
  - Increments by 1 on every output transfer and wraps 0xFFFF -> 0x0000.
  - Reset value is 0.
  - Does not change the timing of any other port.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package adder_fc_pkg:
  - localparam operand_width = 8.
  - typedef enum logic [0:0] { A_WAIT, B_WAIT } collector_state_t.
  - localparam fifo_depth = 2.
- Sub-module ff_fifo_depth_2 (parameter width): registered 2-entry FIFO.
  - Ports: clk, rst, push, push_data, pop, pop_data, empty, full.
- Top-level logic is the FSM, a_q, and in_ready/out_valid glue.

Test Plan:
1. Reset then idle: after rst is held 2 cycles -> out_valid = 0, in_ready = 1, half_pair = 0, out_a/out_b = 0x00.
2. Bytes 0x12, 0x34 back-to-back with out_ready = 1 -> half_pair = 1 after the first byte. out_valid = 1 with out_a = 0x12, out_b = 0x34 exactly one cycle after 0x34 is accepted, for a single cycle.
3. out_ready = 0, stream 0x01..0x06 -> pairs (01,02) and (03,04) are queued. in_ready = 0 in B_WAIT holding 0x05. When out_ready rises, pairs pop in order, then (05,06) is accepted and appears.
4. Backpressure stability: out_valid held with out_ready = 0 for 5 cycles -> out_a/out_b unchanged. Exactly one pop occurs on the cycle out_ready = 1.
5. Reset mid-pair: accept 0xAA, assert rst, then send 0xBB, 0xCC -> the first output is (BB,CC). 0xAA never appears.
6. With ADDER_OPERAND_COLLECTOR_PAIR_COUNT_EN: 3 pairs delivered -> pair_cnt = 3. Force the counter to 0xFFFF plus one pop -> 0x0000.
